mem_access_unit: RTL and testbench
==================================

# mem_access_unit

CPU-side initiator for the 32 x 8 data memory. Accepts single-byte load/store requests and multi-byte copy/fill requests from the control unit over a req/done handshake, then sequences the memory's address, write-enable and write-data lines. Read data is captured from the memory's combinational read port. Sits between the CPU control/datapath and the data memory, and is the only driver of the memory port.

## Interface
Parameters:
- ADDR_W, 5, memory address width; depth is 2^ADDR_W = 32
- DATA_W, 8, data width

Ports (one clock; reset is synchronous and active-high):
- Clk  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-high; returns the block to IDLE
- Req  in  1  request strobe; sampled only when Busy=0
- Op  in  2  operation: 00 LOAD, 01 STORE, 10 COPY, 11 FILL
- Addr_a  in  ADDR_W  LOAD/STORE address; COPY source; FILL start address
- Addr_b  in  ADDR_W  COPY destination; ignored otherwise
- Len  in  ADDR_W  byte count for COPY/FILL, 0..31; ignored for LOAD/STORE
- Wdata  in  DATA_W  STORE data; FILL value
- Rdata  out  DATA_W  last LOAD result; holds until the next LOAD completes
- Busy  out  1  operation in progress
- Done  out  1  one-cycle completion pulse
- Mem_Address  out  ADDR_W  to memory Address
- Mem_Data_in  out  DATA_W  to memory Data_in
- Mem_En  out  1  to memory En (write enable)
- Mem_Data_out  in  DATA_W  from memory Data_out (combinational read)

## Operation
- FSM states: IDLE, LOAD, STORE, CP_RD, CP_WR, FILL, DONE.
- Accept: at a rising edge with Req=1 and state IDLE. Op, Addr_a, Addr_b, Len and Wdata are latched; later input changes have no effect. Busy=0 only in IDLE, so a Req while Busy is ignored and not queued.
- LOAD: drive Mem_Address=Addr_a with Mem_En=0 for one cycle; Rdata <= Mem_Data_out at the end of that cycle; then DONE.
- STORE: drive Mem_Address=Addr_a, Mem_Data_in=Wdata, Mem_En=1 for one cycle; then DONE.
- COPY, per byte:
  - CP_RD: address src, Mem_En=0; latch the byte into an internal buffer.
  - CP_WR: address dst, Mem_Data_in=buffer, Mem_En=1.
  - Then src++, dst++, count--. Repeat until count=0, then DONE.
  - Ascending order, strictly byte-by-byte. Overlapping regions with dst>src therefore replicate source bytes; this is the defined behaviour.
- FILL: one write cycle per byte (address++, Mem_Data_in=Wdata, Mem_En=1) until count=0; then DONE.
- Len=0 for COPY/FILL: go straight to DONE. No memory access.
- Address arithmetic is modulo 2^ADDR_W: 31+1 wraps to 0.
- DONE: Done=1 and Busy=1 for one cycle; then IDLE.
- Mem_En is 1 only in STORE, CP_WR and FILL.
- In non-write states, Mem_Address and Mem_Data_in are don't-care but must be registered or state-derived (no glitching paths from Req).

## Timing
- Request accepted at edge E0. Busy=1 from the cycle after E0 through the DONE cycle inclusive.
- Done-pulse cycle, counted after E0:
  - LOAD/STORE: 2nd cycle.
  - COPY: 2*Len+1.
  - FILL: Len+1.
  - Len=0: 1st cycle.
- Rdata updates at the edge ending the LOAD cycle, so it is valid in the same cycle Done=1.
- Back-to-back: the next Req can be accepted at the edge ending the cycle after DONE, when the state is IDLE again.
- Reset (synchronous) at any point:
  - Next cycle: state=IDLE; Busy, Done, Mem_En, Mem_Address, Mem_Data_in and Rdata all 0.
  - An in-flight operation aborts. Bytes already written stay written; no further writes occur.
  - Reset has priority over a Req at the same edge.

## Structure
- Shared package `cpu_pkg`: Op encodings (OP_LOAD, OP_STORE, OP_COPY, OP_FILL), the FSM state enum, and ADDR_W/DATA_W defaults.
- Single module; no sub-module required. The bench instantiates the existing data memory as the responder, sharing Clk/Reset.

## Test plan
- After Reset, LOAD Addr_a=1 -> Done in cycle 2, Rdata=8'h04; LOAD Addr_a=4 -> Rdata=8'hFF.
- STORE Wdata=8'h5A at 7, then LOAD 7 -> Rdata=8'h5A; Mem_En high for exactly one cycle.
- COPY Addr_a=1, Addr_b=10, Len=3 -> mem[10..12]=04,02,03; Done in cycle 7; Mem_En pattern 0,1,0,1,0,1.
- FILL Addr_a=30, Len=4, Wdata=8'hAA -> mem[30],[31],[0],[1]=AA (wrap); mem[2] unchanged at 02; Done in cycle 5.
- COPY with Len=0 -> Done in cycle 1, Mem_En never high; Req asserted while Busy -> ignored, no second Done.
- Reset asserted after the 2nd CP_WR of a Len=5 COPY -> exactly two destination bytes written; Busy=0 and all outputs 0 the next cycle; a new LOAD afterwards behaves normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, op encodings and FSM states for the memory access unit
//
// Purpose: common definitions imported by the memory access unit, its
//          interface and the bench.
// Contents:
//   ADDR_W / DATA_W  default address and data widths of the 32 x 8 data memory
//   op_e             control-unit operation codes
//   state_e          memory access unit FSM states
//   is_write_state   true for states that assert the memory write enable

package cpu_pkg;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      OP_LOAD  = 2'b00,
      OP_STORE = 2'b01,
      OP_COPY  = 2'b10,
      OP_FILL  = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_STORE = 3'd2,
      ST_CP_RD = 3'd3,
      ST_CP_WR = 3'd4,
      ST_FILL  = 3'd5,
      ST_DONE  = 3'd6
   } state_e;

   // Only these three states ever write the memory.
   function automatic logic is_write_state(input state_e s);
      return (s == ST_STORE) || (s == ST_CP_WR) || (s == ST_FILL);
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request/done handshake plus data memory port bundle
//
// Purpose: groups the control-unit request handshake and the data memory
//          port into one bundle.
// Signals:
//   Req, Op, Addr_a, Addr_b, Len, Wdata   request from the control unit
//   Rdata, Busy, Done                     status/result back to the control unit
//   Mem_Address, Mem_Data_in, Mem_En      drive lines towards the data memory
//   Mem_Data_out                          combinational read data from the memory
// Modports:
//   slave   the memory access unit (serves requests, owns the memory port)
//   master  the environment: control unit plus data memory

interface mem_access_unit_if #(
   parameter int ADDR_W = cpu_pkg::ADDR_W,
   parameter int DATA_W = cpu_pkg::DATA_W
) ();

   logic              Req;
   logic [1:0]        Op;
   logic [ADDR_W-1:0] Addr_a;
   logic [ADDR_W-1:0] Addr_b;
   logic [ADDR_W-1:0] Len;
   logic [DATA_W-1:0] Wdata;
   logic [DATA_W-1:0] Rdata;
   logic              Busy;
   logic              Done;
   logic [ADDR_W-1:0] Mem_Address;
   logic [DATA_W-1:0] Mem_Data_in;
   logic              Mem_En;
   logic [DATA_W-1:0] Mem_Data_out;

   modport slave (
      input  Req, Op, Addr_a, Addr_b, Len, Wdata, Mem_Data_out,
      output Rdata, Busy, Done, Mem_Address, Mem_Data_in, Mem_En
   );

   modport master (
      output Req, Op, Addr_a, Addr_b, Len, Wdata, Mem_Data_out,
      input  Rdata, Busy, Done, Mem_Address, Mem_Data_in, Mem_En
   );

endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - CPU-side sequencer for single-byte and block accesses to the data memory
//
// Purpose: accepts LOAD/STORE/COPY/FILL requests from the control unit and
//          sequences the data memory's address, write-enable and write-data
//          lines, one memory cycle per state.
// Ports:
//   Clk    in   system clock, rising edge
//   Reset  in   synchronous, active-high; aborts any operation, returns to IDLE
//   bus    slave side of mem_access_unit_if (request handshake + memory port)
// All outputs are decoded from the state register or taken straight from
// registers, so nothing on the memory port follows Req combinationally.

module mem_access_unit
   import cpu_pkg::*;
#(
   parameter int ADDR_W = cpu_pkg::ADDR_W,
   parameter int DATA_W = cpu_pkg::DATA_W
) (
   input  logic             Clk,
   input  logic             Reset,
   mem_access_unit_if.slave bus
);

   state_e            r_state;
   state_e            w_next_state;

   // r_src doubles as the LOAD/STORE address and the FILL write pointer.
   logic [ADDR_W-1:0] r_src;
   logic [ADDR_W-1:0] r_dst;
   logic [ADDR_W-1:0] r_cnt;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_buf;
   logic [DATA_W-1:0] r_rdata;

   logic              w_busy;
   logic              w_done;
   logic              w_mem_en;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [DATA_W-1:0] w_mem_wdata;
   logic              w_last_byte;

   // Count still holds the byte being finished, so 1 means this is the last one.
   assign w_last_byte = (r_cnt == ADDR_W'(1));

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_busy       = 1'b1;
      w_done       = 1'b0;
      w_mem_en     = is_write_state(r_state);
      w_mem_addr   = r_src;
      w_mem_wdata  = r_wdata;

      case (r_state)
         ST_IDLE: begin
            w_busy = 1'b0;
            if (bus.Req) begin
               case (bus.Op)
                  OP_LOAD:  w_next_state = ST_LOAD;
                  OP_STORE: w_next_state = ST_STORE;
                  OP_COPY:  w_next_state = (bus.Len == '0) ? ST_DONE : ST_CP_RD;
                  default:  w_next_state = (bus.Len == '0) ? ST_DONE : ST_FILL;
               endcase
            end
         end
         ST_LOAD:  w_next_state = ST_DONE;
         ST_STORE: w_next_state = ST_DONE;
         ST_CP_RD: w_next_state = ST_CP_WR;
         ST_CP_WR: begin
            w_mem_addr   = r_dst;
            w_mem_wdata  = r_buf;
            w_next_state = w_last_byte ? ST_DONE : ST_CP_RD;
         end
         ST_FILL:  w_next_state = w_last_byte ? ST_DONE : ST_FILL;
         ST_DONE: begin
            w_done       = 1'b1;
            w_next_state = ST_IDLE;
         end
         default:  w_next_state = ST_IDLE;
      endcase
   end

   // Datapath registers. Request fields are captured only on acceptance, so
   // later input changes cannot disturb an operation in flight.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_src   <= '0;
         r_dst   <= '0;
         r_cnt   <= '0;
         r_wdata <= '0;
         r_buf   <= '0;
         r_rdata <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.Req) begin
                  r_src   <= bus.Addr_a;
                  r_dst   <= bus.Addr_b;
                  r_cnt   <= bus.Len;
                  r_wdata <= bus.Wdata;
               end
            end
            ST_LOAD:  r_rdata <= bus.Mem_Data_out;
            ST_CP_RD: r_buf   <= bus.Mem_Data_out;
            ST_CP_WR: begin
               // Strictly ascending, byte at a time: an overlapping copy with
               // dst > src re-reads bytes it already wrote and replicates them.
               r_src <= r_src + ADDR_W'(1);
               r_dst <= r_dst + ADDR_W'(1);
               r_cnt <= r_cnt - ADDR_W'(1);
            end
            ST_FILL: begin
               r_src <= r_src + ADDR_W'(1);
               r_cnt <= r_cnt - ADDR_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign bus.Rdata       = r_rdata;
   assign bus.Busy        = w_busy;
   assign bus.Done        = w_done;
   assign bus.Mem_En      = w_mem_en;
   assign bus.Mem_Address = w_mem_addr;
   assign bus.Mem_Data_in = w_mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed vector bench for mem_access_unit with a 32 x 8 memory model
module tb_mem_access_unit;
   import cpu_pkg::*;

   logic Clk = 1'b0;
   logic Reset;
   logic mem_init;
   always #5 Clk = ~Clk;

   mem_access_unit_if bus ();

   mem_access_unit dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   // Data memory responder: synchronous write, combinational read.
   logic [7:0] mem [32];

   function automatic logic [7:0] init_val(input int i);
      if (i == 1) return 8'h04;
      if (i == 4) return 8'hFF;
      return 8'(i);
   endfunction

   always @(posedge Clk) begin
      if (mem_init) begin
         for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
      end else if (bus.Mem_En) begin
         mem[bus.Mem_Address] <= bus.Mem_Data_in;
      end
   end

   assign bus.Mem_Data_out = mem[bus.Mem_Address];

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Issues one request and follows it to its Done pulse (bounded).
   // done_cyc = cycle after acceptance in which Done was seen (0 = never),
   // en_pat bit k-1 = Mem_En during cycle k, busy_ok = Busy held up to Done.
   task automatic run_op(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] len, input logic [7:0] wd,
                         output int done_cyc, output logic [31:0] en_pat, output logic busy_ok);
      @(negedge Clk);
      bus.Req = 1'b1; bus.Op = op; bus.Addr_a = a; bus.Addr_b = b; bus.Len = len; bus.Wdata = wd;
      @(posedge Clk);
      done_cyc = 0; en_pat = '0; busy_ok = 1'b1;
      for (int k = 1; k <= 40 && done_cyc == 0; k++) begin
         @(negedge Clk);
         if (k == 1) begin
            bus.Req = 1'b0; bus.Addr_a = ~a; bus.Addr_b = ~b; bus.Wdata = ~wd;
         end
         if (!bus.Busy) busy_ok = 1'b0;
         if (bus.Mem_En && k <= 32) en_pat[k-1] = 1'b1;
         if (bus.Done) done_cyc = k;
      end
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [4:0]  a;
      logic [4:0]  b;
      logic [4:0]  len;
      logic [7:0]  wd;
      int          done;
      logic [31:0] en;
      logic [7:0]  rdata;
   } vec_t;

   vec_t v [17];

   initial begin
      int          dc;
      logic [31:0] ep;
      logic        bo;
      int          dcount;
      int          dfirst;
      logic        en_seen;

      //            op        a      b      len    wd     done en        rdata
      v[0]  = '{OP_LOAD,  5'd1,  5'd0,  5'd0,  8'h00, 2, 32'h00, 8'h04};
      v[1]  = '{OP_LOAD,  5'd4,  5'd0,  5'd0,  8'h00, 2, 32'h00, 8'hFF};
      v[2]  = '{OP_STORE, 5'd7,  5'd0,  5'd0,  8'h5A, 2, 32'h01, 8'hFF};
      v[3]  = '{OP_LOAD,  5'd7,  5'd0,  5'd0,  8'h00, 2, 32'h00, 8'h5A};
      v[4]  = '{OP_COPY,  5'd1,  5'd10, 5'd3,  8'h00, 7, 32'h2A, 8'h5A};
      v[5]  = '{OP_LOAD,  5'd10, 5'd0,  5'd0,  8'h00, 2, 32'h00, 8'h04};
      v[6]  = '{OP_LOAD,  5'd11, 5'd0,  5'd0,  8'h00, 2, 32'h00, 8'h02};
      v[7]  = '{OP_LOAD,  5'd12, 5'd0,  5'd0,  8'h00, 2, 32'h00, 8'h03};
      v[8]  = '{OP_FILL,  5'd30, 5'd0,  5'd4,  8'hAA, 5, 32'h0F, 8'h03};
      v[9]  = '{OP_LOAD,  5'd30, 5'd0,  5'd0,  8'h00, 2, 32'h00, 8'hAA};
      v[10] = '{OP_LOAD,  5'd31, 5'd0,  5'd0,  8'h00, 2, 32'h00, 8'hAA};
      v[11] = '{OP_LOAD,  5'd0,  5'd0,  5'd0,  8'h00, 2, 32'h00, 8'hAA};
      v[12] = '{OP_LOAD,  5'd1,  5'd0,  5'd0,  8'h00, 2, 32'h00, 8'hAA};
      v[13] = '{OP_LOAD,  5'd2,  5'd0,  5'd0,  8'h00, 2, 32'h00, 8'h02};
      v[14] = '{OP_COPY,  5'd5,  5'd6,  5'd0,  8'h00, 1, 32'h00, 8'h02};
      v[15] = '{OP_FILL,  5'd9,  5'd0,  5'd0,  8'h77, 1, 32'h00, 8'h02};
      v[16] = '{OP_LOAD,  5'd9,  5'd0,  5'd0,  8'h00, 2, 32'h00, 8'h09};

      bus.Req = 1'b0; bus.Op = 2'b00; bus.Addr_a = '0; bus.Addr_b = '0; bus.Len = '0; bus.Wdata = '0;
      Reset = 1'b1; mem_init = 1'b1;
      repeat (3) @(negedge Clk);
      check("reset_busy",  {31'd0, bus.Busy},   32'd0);
      check("reset_done",  {31'd0, bus.Done},   32'd0);
      check("reset_en",    {31'd0, bus.Mem_En}, 32'd0);
      check("reset_addr",  {27'd0, bus.Mem_Address}, 32'd0);
      check("reset_wdata", {24'd0, bus.Mem_Data_in}, 32'd0);
      check("reset_rdata", {24'd0, bus.Rdata},  32'd0);
      Reset = 1'b0; mem_init = 1'b0;

      for (int i = 0; i < 17; i++) begin
         run_op(v[i].op, v[i].a, v[i].b, v[i].len, v[i].wd, dc, ep, bo);
         check($sformatf("v%0d_done_cycle", i), dc, v[i].done);
         check($sformatf("v%0d_en_pattern", i), ep, v[i].en);
         check($sformatf("v%0d_busy", i), {31'd0, bo}, 32'd1);
         check($sformatf("v%0d_rdata", i), {24'd0, bus.Rdata}, {24'd0, v[i].rdata});
         @(negedge Clk);
         check($sformatf("v%0d_idle", i), {30'd0, bus.Busy, bus.Done}, 32'd0);
      end
      check("copy_dst_mem10", {24'd0, mem[10]}, 32'h04);
      check("fill_mem2_kept", {24'd0, mem[2]},  32'h02);

      // Req held high while busy, with different fields: must be ignored.
      @(negedge Clk);
      bus.Req = 1'b1; bus.Op = OP_FILL; bus.Addr_a = 5'd20; bus.Len = 5'd3; bus.Wdata = 8'h11;
      @(posedge Clk);
      dcount = 0; dfirst = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge Clk);
         if (k == 1) begin bus.Op = OP_STORE; bus.Addr_a = 5'd5; bus.Wdata = 8'hEE; end
         if (k == 3) bus.Req = 1'b0;
         if (bus.Done) begin
            dcount++;
            if (dfirst == 0) dfirst = k;
         end
      end
      check("busy_req_done_count", dcount, 1);
      check("busy_req_done_cycle", dfirst, 4);
      check("fill20", {24'd0, mem[20]}, 32'h11);
      check("fill22", {24'd0, mem[22]}, 32'h11);
      check("fill23_kept", {24'd0, mem[23]}, 32'h17);
      check("store5_not_queued", {24'd0, mem[5]}, 32'h05);

      // Reset during the 2nd CP_WR of a Len=5 COPY from 1 to 24.
      @(negedge Clk);
      bus.Req = 1'b1; bus.Op = OP_COPY; bus.Addr_a = 5'd1; bus.Addr_b = 5'd24; bus.Len = 5'd5;
      @(posedge Clk);
      for (int k = 1; k <= 4; k++) begin
         @(negedge Clk);
         if (k == 1) bus.Req = 1'b0;
      end
      check("cp_wr2_en", {31'd0, bus.Mem_En}, 32'd1);
      Reset = 1'b1;
      @(negedge Clk);
      check("abort_busy",  {31'd0, bus.Busy},   32'd0);
      check("abort_done",  {31'd0, bus.Done},   32'd0);
      check("abort_en",    {31'd0, bus.Mem_En}, 32'd0);
      check("abort_addr",  {27'd0, bus.Mem_Address}, 32'd0);
      check("abort_wdata", {24'd0, bus.Mem_Data_in}, 32'd0);
      check("abort_rdata", {24'd0, bus.Rdata},  32'd0);
      Reset = 1'b0;
      en_seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge Clk);
         if (bus.Mem_En || bus.Done) en_seen = 1'b1;
      end
      check("abort_quiet", {31'd0, en_seen}, 32'd0);
      check("abort_mem24", {24'd0, mem[24]}, 32'hAA);
      check("abort_mem25", {24'd0, mem[25]}, 32'h02);
      check("abort_mem26", {24'd0, mem[26]}, 32'h1A);
      check("abort_mem27", {24'd0, mem[27]}, 32'h1B);

      run_op(OP_LOAD, 5'd25, 5'd0, 5'd0, 8'h00, dc, ep, bo);
      check("post_reset_load_done", dc, 2);
      check("post_reset_load_rdata", {24'd0, bus.Rdata}, 32'h02);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
